s_shift_acc: RTL and testbench

S_SHIFT_ACC -- requirements
Module: s_shift_acc

---
 rtl/s_shift_acc.sv | 120 ++++++++++++
 tb/tb_s_shift_acc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/s_shift_acc.sv
// Bit-serial shift-accumulator: sums sign-extended partial sums shifted by bit-plane index into a 24-bit result.
// One plane per accepted cycle, result valid the cycle after the last plane; psum_ready drops while a result waits.
module s_shift_acc #(
  parameter int IN_BITS = 8,
  parameter int PSUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum,
  input  logic              signed_in,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [23:0]       acc_out,
  output logic              acc_ovf
);

  generate
    if (IN_BITS < 1 || IN_BITS > 16 || PSUM_W + IN_BITS - 1 > 24) begin : g_bad_params
      $error("s_shift_acc: IN_BITS must be 1..16 and PSUM_W+IN_BITS-1 <= 24");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_PLANE = 5'(IN_BITS - 1);

  state_t      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        ovf_q, ovf_d;

  logic [23:0] psum_ext;
  logic [23:0] term;
  logic [23:0] add_a;
  logic [23:0] add_b;
  logic [23:0] add_sum;
  logic        neg;
  logic        add_ovf;

  // The MSB plane of a signed input carries negative weight: subtract it via inverse plus carry-in.
  always_comb begin
    psum_ext = 24'($signed(psum));
    term     = psum_ext << cnt_q;
    neg      = (cnt_q == LAST_PLANE) && ((state_q == S_IDLE) ? signed_in : mode_q);
    add_a    = (state_q == S_IDLE) ? 24'd0 : acc_q;
    add_b    = neg ? ~term : term;
    add_sum  = add_a + add_b + {23'd0, neg};
    add_ovf  = (add_a[23] == add_b[23]) && (add_sum[23] != add_a[23]);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (psum_valid) begin
          acc_d   = add_sum;
          cnt_d   = 5'd1;
          mode_d  = signed_in;
          ovf_d   = add_ovf;
          state_d = (IN_BITS == 1) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (psum_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_q + 5'd1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == LAST_PLANE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (acc_ready) begin
          state_d = S_IDLE;
          acc_d   = 24'd0;
          cnt_d   = 5'd0;
          mode_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 24'd0;
      cnt_q   <= 5'd0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign psum_ready = (state_q != S_DONE);
  assign acc_valid  = (state_q == S_DONE);
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_s_shift_acc.sv
// Randomized bench for s_shift_acc: three instances (8x16, 1x16, 8x17) share stimulus, one active at a time.
module tb_s_shift_acc;

  logic        clk;
  logic        rst_n;
  logic        psum_valid;
  logic [16:0] psum;
  logic        signed_in;
  logic        acc_ready;
  int          sel;

  logic        pv0, pv1, pv2;
  logic        prdy0, prdy1, prdy2;
  logic        avld0, avld1, avld2;
  logic [23:0] acc0, acc1, acc2;
  logic        ovf0, ovf1, ovf2;

  logic        obs_prdy, obs_avld, obs_ovf;
  logic [23:0] obs_acc;

  int nchk;
  int npass;

  assign pv0 = psum_valid && (sel == 0);
  assign pv1 = psum_valid && (sel == 1);
  assign pv2 = psum_valid && (sel == 2);

  s_shift_acc #(.IN_BITS(8), .PSUM_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .psum_valid(pv0), .psum_ready(prdy0), .psum(psum[15:0]),
    .signed_in(signed_in), .acc_valid(avld0), .acc_ready(acc_ready), .acc_out(acc0), .acc_ovf(ovf0));

  s_shift_acc #(.IN_BITS(1), .PSUM_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psum_valid(pv1), .psum_ready(prdy1), .psum(psum[15:0]),
    .signed_in(signed_in), .acc_valid(avld1), .acc_ready(acc_ready), .acc_out(acc1), .acc_ovf(ovf1));

  s_shift_acc #(.IN_BITS(8), .PSUM_W(17)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .psum_valid(pv2), .psum_ready(prdy2), .psum(psum),
    .signed_in(signed_in), .acc_valid(avld2), .acc_ready(acc_ready), .acc_out(acc2), .acc_ovf(ovf2));

  always_comb begin
    obs_prdy = prdy0;
    obs_avld = avld0;
    obs_acc  = acc0;
    obs_ovf  = ovf0;
    if (sel == 1) begin
      obs_prdy = prdy1; obs_avld = avld1; obs_acc = acc1; obs_ovf = ovf1;
    end else if (sel == 2) begin
      obs_prdy = prdy2; obs_avld = avld2; obs_acc = acc2; obs_ovf = ovf2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", tag, sel, obs, exp);
  endtask

  // Reference: exact integer sum of plane*2^k, MSB plane negated for signed input,
  // each step wrapped to 24 bits and flagged if the true step result leaves the signed range.
  function automatic void model(input int nb, input int p[16], input bit sgn,
                                output logic [23:0] e_acc, output bit e_ovf);
    longint acc, t, s;
    acc   = 0;
    e_ovf = 1'b0;
    for (int k = 0; k < nb; k++) begin
      t = longint'(p[k]) * (longint'(1) << k);
      if (sgn && k == nb - 1) t = -t;
      s = acc + t;
      if (s > 8388607 || s < -8388608) e_ovf = 1'b1;
      acc = ((s % 16777216) + 16777216) % 16777216;
      if (acc > 8388607) acc -= 16777216;
    end
    e_acc = 24'(acc);
  endfunction

  // mode: 0 back-to-back, 1 alternating valid, 2 random valid
  task automatic drive_planes(input int n, input int p[16], input bit sgn, input int mode);
    int k, cyc;
    bit v;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      psum_valid = v;
      psum       = v ? 17'(p[k]) : 17'($urandom);
      signed_in  = (v && k == 0) ? sgn : 1'($urandom_range(0, 1));
      acc_ready  = 1'($urandom_range(0, 1));
      if (v) begin
        check("plane_ready", 32'(obs_prdy), 32'd1);
        k++;
      end
    end
    if (k < n) check("plane_timeout", 32'(k), 32'(n));
  endtask

  task automatic run_txn(input int s, input int p[16], input bit sgn, input int mode,
                         input int delay, input bit use_k, input logic [23:0] k_acc, input bit k_ovf);
    int nb, w;
    logic [23:0] e_acc;
    bit e_ovf;
    sel = s;
    nb  = (s == 1) ? 1 : 8;
    model(nb, p, sgn, e_acc, e_ovf);
    drive_planes(nb, p, sgn, mode);
    @(negedge clk);
    psum_valid = 1'b0;
    psum       = 17'($urandom);
    acc_ready  = 1'b0;
    check("latency", 32'(obs_avld), 32'd1);
    w = 0;
    while (!obs_avld && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!obs_avld) begin
      check("valid_timeout", 32'(obs_avld), 32'd1);
      return;
    end
    check("acc_out", 32'(obs_acc), 32'(e_acc));
    check("acc_ovf", 32'(obs_ovf), 32'(e_ovf));
    check("done_ready", 32'(obs_prdy), 32'd0);
    if (use_k) begin
      check("acc_const", 32'(obs_acc), 32'(k_acc));
      check("ovf_const", 32'(obs_ovf), 32'(k_ovf));
    end
    for (int i = 0; i < delay; i++) begin
      psum_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", 32'(obs_avld), 32'd1);
      check("hold_acc", 32'(obs_acc), 32'(e_acc));
      check("hold_ovf", 32'(obs_ovf), 32'(e_ovf));
      check("hold_ready", 32'(obs_prdy), 32'd0);
    end
    psum_valid = 1'b0;
    acc_ready  = 1'b1;
    @(negedge clk);
    acc_ready = 1'($urandom_range(0, 1));
    check("idle_valid", 32'(obs_avld), 32'd0);
    check("idle_ready", 32'(obs_prdy), 32'd1);
    check("idle_acc", 32'(obs_acc), 32'd0);
    check("idle_ovf", 32'(obs_ovf), 32'd0);
  endtask

  initial begin
    int p[16];
    int s;
    nchk       = 0;
    npass      = 0;
    sel        = 0;
    rst_n      = 1'b0;
    psum_valid = 1'b0;
    psum       = '0;
    signed_in  = 1'b0;
    acc_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_acc", 32'(obs_acc), 32'd0);
      check("rst_valid", 32'(obs_avld), 32'd0);
      check("rst_ovf", 32'(obs_ovf), 32'd0);
      check("rst_ready", 32'(obs_prdy), 32'd1);
    end

    // unsigned all-ones planes
    for (int k = 0; k < 16; k++) p[k] = 1;
    run_txn(0, p, 1'b0, 0, 0, 1'b1, 24'h0000FF, 1'b0);

    // signed, only MSB plane set
    for (int k = 0; k < 16; k++) p[k] = 0;
    p[7] = 3;
    run_txn(0, p, 1'b1, 0, 1, 1'b1, 24'hFFFE80, 1'b0);

    // alternating valid, 5 cycles of result backpressure
    for (int k = 0; k < 16; k++) p[k] = 2;
    run_txn(0, p, 1'b0, 1, 5, 1'b1, 24'd510, 1'b0);

    // overflow on the 17-bit instance, then a clean transaction
    for (int k = 0; k < 16; k++) p[k] = 65535;
    run_txn(2, p, 1'b0, 0, 2, 1'b1, 24'hFEFF01, 1'b1);
    for (int k = 0; k < 16; k++) p[k] = 0;
    run_txn(2, p, 1'b0, 0, 0, 1'b1, 24'd0, 1'b0);

    // reset mid-transaction; the plane offered during reset must be dropped
    sel = 0;
    for (int k = 0; k < 16; k++) p[k] = 7;
    drive_planes(3, p, 1'b0, 0);
    @(negedge clk);
    rst_n      = 1'b0;
    psum_valid = 1'b1;
    psum       = 17'd9;
    @(negedge clk);
    rst_n      = 1'b1;
    psum_valid = 1'b0;
    check("midrst_acc", 32'(obs_acc), 32'd0);
    check("midrst_valid", 32'(obs_avld), 32'd0);
    check("midrst_ready", 32'(obs_prdy), 32'd1);
    check("midrst_ovf", 32'(obs_ovf), 32'd0);
    for (int k = 0; k < 16; k++) p[k] = 0;
    p[0] = 5;
    run_txn(0, p, 1'b0, 0, 0, 1'b1, 24'd5, 1'b0);

    // single-plane instance: signed MSB plane is negated
    for (int k = 0; k < 16; k++) p[k] = 0;
    p[0] = -4;
    run_txn(1, p, 1'b1, 0, 0, 1'b1, 24'd4, 1'b0);

    for (int t = 0; t < 40; t++) begin
      s = int'($urandom_range(0, 2));
      for (int k = 0; k < 16; k++) begin
        if (s == 2) p[k] = int'($urandom_range(0, 131071)) - 65536;
        else        p[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_txn(s, p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 1'b0, 24'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
